// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: read-side FSM encoding and default widths.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_READY = 2'b10
    } state_e;

    localparam int DW_DEFAULT = 8;
    localparam int AW_DEFAULT = 4;

endpackage

// File: rtl/uart_tx_fifo_ram.sv
// Simple dual-port store: synchronous write, registered read output that doubles as dout.
module uart_tx_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rd_data;

    // storage array, left unreset so it maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // output register holds the last word loaded until the next read
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rd_data <= {DW{1'b0}};
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the core and uart_tx: pointers, status flags and the
// next/dout_ready read handshake FSM.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int AW        = AW_DEFAULT,
    parameter int AF_MARGIN = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          flush,
    input  logic          en,
    input  logic          next,
    output logic [DW-1:0] dout,
    output logic          dout_ready,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] AF_LEVEL = (AW+1)'((2**AW) - AF_MARGIN);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_overflow;
    logic        r_dout_ready;
    state_e      r_state;
    state_e      w_state_nxt;
    logic        w_dout_ready_nxt;
    logic        w_load;
    logic        w_pop;
    logic        w_wr_accept;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;

    assign w_count     = r_wptr - r_rptr;
    assign w_full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_empty     = (r_wptr == r_rptr);
    // full is sampled before any same-cycle pop, so a write when full is always dropped
    assign w_wr_accept = wr_en & ~w_full & ~flush;

    uart_tx_fifo_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wptr[AW-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_load),
        .i_rd_addr (r_rptr[AW-1:0]),
        .o_rd_data (dout)
    );

    // read FSM next-state; flush ends a pending delivery without consuming the word
    always_comb begin
        w_state_nxt      = r_state;
        w_dout_ready_nxt = r_dout_ready;
        w_load           = 1'b0;
        w_pop            = 1'b0;
        if (flush) begin
            if (r_state == S_READY) begin
                w_state_nxt      = S_IDLE;
                w_dout_ready_nxt = 1'b0;
            end else begin
                w_state_nxt      = r_state;
            end
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (next && !w_empty) begin
                        w_state_nxt      = S_READY;
                        w_dout_ready_nxt = 1'b1;
                        w_load           = 1'b1;
                    end else if (next) begin
                        w_state_nxt      = S_WAIT;
                    end else begin
                        w_state_nxt      = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!w_empty) begin
                        w_state_nxt      = S_READY;
                        w_dout_ready_nxt = 1'b1;
                        w_load           = 1'b1;
                    end else begin
                        w_state_nxt      = S_WAIT;
                    end
                end
                S_READY: begin
                    w_state_nxt      = S_IDLE;
                    w_dout_ready_nxt = 1'b0;
                    w_pop            = 1'b1;
                end
                default: begin
                    w_state_nxt      = S_IDLE;
                    w_dout_ready_nxt = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // read FSM state and dout_ready pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_dout_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dout_ready <= w_dout_ready_nxt;
        end
    end

    // pointers and sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= {(AW+1){1'b0}};
            r_rptr     <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wptr     <= {(AW+1){1'b0}};
            r_rptr     <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= r_wptr + PTR_ONE;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end else begin
                r_rptr <= r_rptr;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    assign dout_ready  = r_dout_ready;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (w_count >= AF_LEVEL);
    assign count       = w_count;
    assign overflow    = r_overflow;

endmodule
